// File: rtl/switch_counter_debounced.sv
// switch_counter_debounced: push-button front end for the 7-segment decoder.
// Synchronizes, debounces and edge-detects four keys that drive a 4-bit counter.
module switch_counter_debounced #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WRAP            = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       btn_clr_n,
    input  logic       btn_load_n,
    input  logic [3:0] sw_value,
    output logic [3:0] count_out,
    output logic       ovf_pulse,
    output logic       unf_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // bit order: 0 inc, 1 dec, 2 clr, 3 load
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    synced;
    logic [3:0]    level;
    logic [3:0]    level_q;
    logic [3:0]    press;
    logic [CW-1:0] db_cnt [4];

    logic          inc_ev;
    logic          dec_ev;
    logic          clr_ev;
    logic          load_ev;

    logic [3:0]    count_next;
    logic          ovf_next;
    logic          unf_next;

    assign raw = {btn_load_n, btn_clr_n, btn_dec_n, btn_inc_n};

    // two-flop synchronizer per button, idles at released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 4'hF;
            synced <= 4'hF;
        end else begin
            sync1  <= raw;
            synced <= sync1;
        end
    end

    // debounce: accept a new level after DEBOUNCE_CYCLES stable synced cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (synced[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    level[i]  <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // registered copy of the debounced level for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 4'hF;
        end else begin
            level_q <= level;
        end
    end

    assign press   = level_q & ~level;
    assign inc_ev  = press[0];
    assign dec_ev  = press[1];
    assign clr_ev  = press[2];
    assign load_ev = press[3];

    // next count: clr > load > (inc xor dec); inc+dec together cancel
    always_comb begin
        count_next = count_out;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (clr_ev) begin
            count_next = 4'd0;
        end else if (load_ev) begin
            count_next = sw_value;
        end else if (inc_ev && !dec_ev) begin
            if (count_out == 4'd15) begin
                ovf_next   = 1'b1;
                count_next = (WRAP != 0) ? 4'd0 : 4'd15;
            end else begin
                count_next = count_out + 4'd1;
            end
        end else if (dec_ev && !inc_ev) begin
            if (count_out == 4'd0) begin
                unf_next   = 1'b1;
                count_next = (WRAP != 0) ? 4'd15 : 4'd0;
            end else begin
                count_next = count_out - 4'd1;
            end
        end
    end

    // count and limit pulses update on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out <= 4'd0;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
        end else begin
            count_out <= count_next;
            ovf_pulse <= ovf_next;
            unf_pulse <= unf_next;
        end
    end

endmodule

// File: tb/tb_switch_counter_debounced.sv
// tb_switch_counter_debounced: directed bench, DEBOUNCE_CYCLES=4.
// One wrapping and one saturating instance share all inputs.
module tb_switch_counter_debounced;

    logic       clk;
    logic       rst_n;
    logic       btn_inc_n;
    logic       btn_dec_n;
    logic       btn_clr_n;
    logic       btn_load_n;
    logic [3:0] sw_value;
    logic [3:0] count_w;
    logic       ovf_w;
    logic       unf_w;
    logic [3:0] count_s;
    logic       ovf_s;
    logic       unf_s;

    int n_checks = 0;
    int n_fail   = 0;

    switch_counter_debounced #(
        .DEBOUNCE_CYCLES(4),
        .WRAP(1)
    ) u_wrap (
        .clk(clk),
        .rst_n(rst_n),
        .btn_inc_n(btn_inc_n),
        .btn_dec_n(btn_dec_n),
        .btn_clr_n(btn_clr_n),
        .btn_load_n(btn_load_n),
        .sw_value(sw_value),
        .count_out(count_w),
        .ovf_pulse(ovf_w),
        .unf_pulse(unf_w)
    );

    switch_counter_debounced #(
        .DEBOUNCE_CYCLES(4),
        .WRAP(0)
    ) u_sat (
        .clk(clk),
        .rst_n(rst_n),
        .btn_inc_n(btn_inc_n),
        .btn_dec_n(btn_dec_n),
        .btn_clr_n(btn_clr_n),
        .btn_load_n(btn_load_n),
        .sw_value(sw_value),
        .count_out(count_s),
        .ovf_pulse(ovf_s),
        .unf_pulse(unf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bits: 0 inc, 1 dec, 2 clr, 3 load (1 = held down)
    task automatic hold(input logic [3:0] mask);
        btn_inc_n  = ~mask[0];
        btn_dec_n  = ~mask[1];
        btn_clr_n  = ~mask[2];
        btn_load_n = ~mask[3];
    endtask

    task automatic release_all();
        hold(4'b0000);
        tick(8);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sw_value = 4'd0;
        hold(4'b0000);
        tick(3);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", count_w);
        end
        n_checks++;
        if (ovf_w !== 1'b0 || unf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b%b want 00", ovf_w, unf_w);
        end
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (count_w !== 4'd0 || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got %0d/%b%b want 0/00",
                     count_w, ovf_w, unf_w);
        end
    endtask

    task automatic test_single_press();
        hold(4'b0001);
        tick(6);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL press_early got %0d want 0", count_w);
        end
        tick(1);
        n_checks++;
        if (count_w !== 4'd1) begin
            n_fail++;
            $display("FAIL press_latency got %0d want 1", count_w);
        end
        tick(50);
        n_checks++;
        if (count_w !== 4'd1) begin
            n_fail++;
            $display("FAIL press_held got %0d want 1", count_w);
        end
        hold(4'b0000);
        tick(10);
        n_checks++;
        if (count_w !== 4'd1) begin
            n_fail++;
            $display("FAIL press_release got %0d want 1", count_w);
        end
    endtask

    task automatic test_bounce();
        hold(4'b0100);
        tick(7);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL bounce_clr got %0d want 0", count_w);
        end
        release_all();
        for (int i = 0; i < 5; i++) begin
            btn_inc_n = 1'b0;
            tick(2);
            btn_inc_n = 1'b1;
            tick(2);
        end
        tick(10);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL bounce_reject got %0d want 0", count_w);
        end
        btn_inc_n = 1'b0;
        tick(10);
        n_checks++;
        if (count_w !== 4'd1) begin
            n_fail++;
            $display("FAIL bounce_stable got %0d want 1", count_w);
        end
        release_all();
    endtask

    task automatic test_wrap();
        sw_value = 4'd15;
        hold(4'b1000);
        tick(7);
        n_checks++;
        if (count_w !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_load got %0d want 15", count_w);
        end
        release_all();
        hold(4'b0001);
        tick(7);
        n_checks++;
        if (count_w !== 4'd0 || ovf_w !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_inc got %0d/ovf %b want 0/1", count_w, ovf_w);
        end
        tick(1);
        n_checks++;
        if (ovf_w !== 1'b0 || count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_ovf_width got %0d/ovf %b want 0/0",
                     count_w, ovf_w);
        end
        release_all();
        hold(4'b0010);
        tick(7);
        n_checks++;
        if (count_w !== 4'd15 || unf_w !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_dec got %0d/unf %b want 15/1", count_w, unf_w);
        end
        tick(1);
        n_checks++;
        if (unf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_unf_width got %b want 0", unf_w);
        end
        release_all();
    endtask

    task automatic test_saturate();
        sw_value = 4'd15;
        hold(4'b1000);
        tick(7);
        release_all();
        hold(4'b0001);
        tick(7);
        n_checks++;
        if (count_s !== 4'd15 || ovf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_inc got %0d/ovf %b want 15/1", count_s, ovf_s);
        end
        tick(1);
        n_checks++;
        if (ovf_s !== 1'b0 || count_s !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_ovf_width got %0d/ovf %b want 15/0",
                     count_s, ovf_s);
        end
        release_all();
        hold(4'b0100);
        tick(7);
        release_all();
        hold(4'b0010);
        tick(7);
        n_checks++;
        if (count_s !== 4'd0 || unf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_dec got %0d/unf %b want 0/1", count_s, unf_s);
        end
        tick(1);
        n_checks++;
        if (unf_s !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_unf_width got %b want 0", unf_s);
        end
        release_all();
    endtask

    task automatic test_simultaneous();
        sw_value = 4'd7;
        hold(4'b1000);
        tick(7);
        release_all();
        hold(4'b0011);
        tick(7);
        n_checks++;
        if (count_w !== 4'd7 || ovf_w !== 1'b0 || unf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL incdec got %0d/%b%b want 7/00",
                     count_w, ovf_w, unf_w);
        end
        tick(1);
        n_checks++;
        if (count_w !== 4'd7) begin
            n_fail++;
            $display("FAIL incdec_after got %0d want 7", count_w);
        end
        release_all();
        sw_value = 4'd5;
        hold(4'b1000);
        tick(7);
        release_all();
        sw_value = 4'd9;
        hold(4'b1100);
        tick(7);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_load got %0d want 0", count_w);
        end
        release_all();
        hold(4'b1000);
        tick(7);
        n_checks++;
        if (count_w !== 4'd9) begin
            n_fail++;
            $display("FAIL load_only got %0d want 9", count_w);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        sw_value = 4'd3;
        hold(4'b1000);
        tick(7);
        release_all();
        hold(4'b0001);
        tick(3);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async got %0d want 0", count_w);
        end
        tick(2);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_hold got %0d want 0", count_w);
        end
        rst_n = 1'b1;
        tick(6);
        n_checks++;
        if (count_w !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_early got %0d want 0", count_w);
        end
        tick(1);
        n_checks++;
        if (count_w !== 4'd1 || ovf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_press got %0d/ovf %b want 1/0", count_w, ovf_w);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
